// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: EX-stage sequencer for the iterative multiply/divide unit
// that owns HI/LO. 32-step shift-add multiply, 32-step restoring divide.
//
// Ports:
//   clock, reset(async, active-low)
//   start, op[1:0] (00 MULT, 01 MULTU, 10 DIV, 11 DIVU), rs_val, rt_val
//   hi_wr, lo_wr, wdata : MTHI/MTLO writes (IDLE only)
//   hilo_rd             : MFHI/MFLO in ID (stall source)
//   flush               : abort in-flight operation
//   hi, lo              : HI/LO registers
//   busy, done          : registered status, done is a one-cycle pulse
//   stall               : busy & (start | hilo_rd | hi_wr | lo_wr)
//
// Build option: define MULDIV_DIV_EN to compile the divide datapath.
// Without it DIV/DIVU always take the zero-divide result path.
module muldiv_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hi_wr,
    input  logic        lo_wr,
    input  logic [31:0] wdata,
    input  logic        hilo_rd,
    input  logic        flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        CALC,
        FIX
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_div;
    logic        r_sa;
    logic        r_sx;
    logic        r_dz;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [63:0] r_acc;
    logic [4:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_accept;
    logic        w_sgn;
    logic        w_rs_neg;
    logic        w_rt_neg;
    logic        w_dz_now;
    logic [32:0] w_sum;
    logic [63:0] w_prod;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_accept = start & ~flush;
    assign w_sgn    = ~op[0];
    assign w_rs_neg = w_sgn & rs_val[31];
    assign w_rt_neg = w_sgn & rt_val[31];

`ifdef MULDIV_DIV_EN
    assign w_dz_now = r_div & (r_b == 32'd0);
`else
    assign w_dz_now = r_div;
`endif

    // Shift-add step: multiplicand r_a added into the upper half when the
    // current multiplier bit (r_b[0]) is set; carry shifts into bit 63.
    assign w_sum = {1'b0, r_acc[63:32]}
                 + (r_b[0] ? {1'b0, r_a} : 33'd0);

`ifdef MULDIV_DIV_EN
    // Restoring divide: r_acc = {remainder, quotient}; dividend bits
    // enter from r_a[31]. The remainder stays below the divisor, so a
    // 32-bit subtract is exact whenever the trial succeeds.
    logic [32:0] w_rem_sh;
    logic        w_qbit;
    logic [31:0] w_rem_new;

    assign w_rem_sh  = {r_acc[63:32], r_a[31]};
    assign w_qbit    = (w_rem_sh >= {1'b0, r_b});
    assign w_rem_new = w_qbit ? (w_rem_sh[31:0] - r_b)
                              : w_rem_sh[31:0];
`endif

    // Final sign correction of the unsigned core result.
    assign w_prod = r_sx ? (64'd0 - r_acc) : r_acc;

    always_comb begin
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
        if (r_div) begin
`ifdef MULDIV_DIV_EN
            if (r_dz) begin
                // r_a holds |rs|; restoring the sign gives rs as latched
                w_res_hi = r_sa ? (32'd0 - r_a) : r_a;
                w_res_lo = 32'hFFFF_FFFF;
            end else begin
                w_res_hi = r_sa ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
                w_res_lo = r_sx ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
            end
`else
            w_res_hi = r_sa ? (32'd0 - r_a) : r_a;
            w_res_lo = 32'hFFFF_FFFF;
`endif
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_accept) w_next = PREP;
            PREP: w_next = w_dz_now ? FIX : CALC;
            CALC: if (r_cnt == 5'd31) w_next = FIX;
            FIX:  w_next = IDLE;
        endcase
        if (flush && (r_state != IDLE)) begin
            w_next = IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_div  <= 1'b0;
            r_sa   <= 1'b0;
            r_sx   <= 1'b0;
            r_dz   <= 1'b0;
            r_a    <= 32'd0;
            r_b    <= 32'd0;
            r_acc  <= 64'd0;
            r_cnt  <= 5'd0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_div <= op[1];
                        r_sa  <= w_rs_neg;
                        r_sx  <= w_rs_neg ^ w_rt_neg;
                        r_dz  <= 1'b0;
                        r_a   <= w_rs_neg ? (32'd0 - rs_val) : rs_val;
                        r_b   <= w_rt_neg ? (32'd0 - rt_val) : rt_val;
                    end else begin
                        if (hi_wr) r_hi <= wdata;
                        if (lo_wr) r_lo <= wdata;
                    end
                end
                PREP: begin
                    r_acc <= 64'd0;
                    r_cnt <= 5'd0;
                    r_dz  <= w_dz_now;
                end
                CALC: begin
                    r_cnt <= r_cnt + 5'd1;
`ifdef MULDIV_DIV_EN
                    if (r_div) begin
                        r_acc <= {w_rem_new, r_acc[30:0], w_qbit};
                        r_a   <= {r_a[30:0], 1'b0};
                    end else begin
                        r_acc <= {w_sum, r_acc[31:1]};
                        r_b   <= {1'b0, r_b[31:1]};
                    end
`else
                    r_acc <= {w_sum, r_acc[31:1]};
                    r_b   <= {1'b0, r_b[31:1]};
`endif
                end
                FIX: begin
                    if (!flush) begin
                        r_hi   <= w_res_hi;
                        r_lo   <= w_res_lo;
                        r_done <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign hi    = r_hi;
    assign lo    = r_lo;
    assign busy  = (r_state != IDLE);
    assign done  = r_done;
    assign stall = busy & (start | hilo_rd | hi_wr | lo_wr);

endmodule
